pe_layer_scheduler: RTL and testbench

//  Sequences one conv layer over the PE array and fm_guard_gen path for the top-level controller.
//  - Accepts a layer descriptor.
//  - Launches every active PE column controller and the fm_guard_gen controller.
//  - Tracks per-column and guard-gen completion; repeats for each output-channel pass.
//  - Pulses layer_done when the layer is complete.
//  - Gates unused columns so the adder trees see zeros from them.

---
 rtl/pe_layer_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_pe_layer_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_layer_scheduler.sv
// pe_layer_scheduler: sequences one conv layer across the PE column controllers
// and the fm_guard_gen controller, repeating for every output-channel pass.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   cfg_valid/ready   layer descriptor handshake (cfg_col_num, cfg_co_pass)
//   abort             synchronous abort pulse, returns to IDLE without layer_done
//   pe_col_valid      per-column start request, held until pe_col_ready
//   pe_col_finish     per-column finished pulse
//   layer_finish_col  sticky per-column finished mask for the current pass
//   gate_col          columns unused by the current layer (adder trees see zero)
//   fg_valid/ready    start handshake to the fm_guard_gen controller
//   fg_finish         fm_guard_gen finished pulse
//   busy              scheduler not idle
//   pass_idx          current output-channel pass, 0-based
//   layer_done        one-cycle pulse when the layer is complete
module pe_layer_scheduler #(
  parameter int unsigned N_COL = 4,
  parameter int unsigned CW    = $clog2(N_COL + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CW-1:0]    cfg_col_num,
  input  logic [7:0]       cfg_co_pass,
  input  logic             abort,
  output logic [N_COL-1:0] pe_col_valid,
  input  logic [N_COL-1:0] pe_col_ready,
  input  logic [N_COL-1:0] pe_col_finish,
  output logic [N_COL-1:0] layer_finish_col,
  output logic [N_COL-1:0] gate_col,
  output logic             fg_valid,
  input  logic             fg_ready,
  input  logic             fg_finish,
  output logic             busy,
  output logic [7:0]       pass_idx,
  output logic             layer_done
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

  state_t           state;
  logic [N_COL-1:0] active;
  logic [N_COL-1:0] launched;
  logic [N_COL-1:0] col_done;
  logic             fg_launched;
  logic             fg_done;
  logic [7:0]       passes;

  logic             accept;
  logic [CW-1:0]    cap_num;
  logic [N_COL-1:0] cap_active;
  logic [7:0]       cap_passes;
  logic [N_COL-1:0] launched_nx;
  logic             fg_launched_nx;
  logic [N_COL-1:0] col_done_nx;
  logic             fg_done_nx;
  logic             all_launched;
  logic             all_done;
  logic             last_pass;

  // Descriptor decode and handshake / completion bookkeeping
  always_comb begin
    accept     = 1'b0;
    cap_num    = cfg_col_num;
    cap_active = '0;
    cap_passes = cfg_co_pass;

    if (state == IDLE) accept = cfg_valid & cfg_ready & ~abort;
    if (cfg_col_num > CW'(N_COL)) cap_num = CW'(N_COL);
    for (int unsigned j = 0; j < N_COL; j++) cap_active[j] = (CW'(j) < cap_num);
    if (cfg_co_pass == 8'd0) cap_passes = 8'd1;

    launched_nx    = launched | (pe_col_valid & pe_col_ready);
    fg_launched_nx = fg_launched | (fg_valid & fg_ready);
    // Finishes only count for columns that were actually started
    col_done_nx    = col_done | (pe_col_finish & launched & active);
    fg_done_nx     = fg_done | (fg_finish & fg_launched);
    all_launched   = ((launched_nx & active) == active) & fg_launched_nx;
    all_done       = ((col_done & active) == active) & fg_done;
    last_pass      = (pass_idx == (passes - 8'd1));
  end

  // Layer sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      active           <= '0;
      launched         <= '0;
      col_done         <= '0;
      fg_launched      <= 1'b0;
      fg_done          <= 1'b0;
      passes           <= 8'd1;
      cfg_ready        <= 1'b1;
      pe_col_valid     <= '0;
      fg_valid         <= 1'b0;
      layer_finish_col <= '0;
      gate_col         <= '1;
      busy             <= 1'b0;
      pass_idx         <= 8'd0;
      layer_done       <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      if (abort && state != IDLE) begin
        state            <= IDLE;
        launched         <= '0;
        col_done         <= '0;
        fg_launched      <= 1'b0;
        fg_done          <= 1'b0;
        cfg_ready        <= 1'b1;
        pe_col_valid     <= '0;
        fg_valid         <= 1'b0;
        layer_finish_col <= '0;
        gate_col         <= '1;
        busy             <= 1'b0;
        pass_idx         <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              active           <= cap_active;
              passes           <= cap_passes;
              pass_idx         <= 8'd0;
              gate_col         <= ~cap_active;
              cfg_ready        <= 1'b0;
              busy             <= 1'b1;
              launched         <= '0;
              col_done         <= '0;
              fg_launched      <= 1'b0;
              fg_done          <= 1'b0;
              layer_finish_col <= '0;
              // Empty layer completes without launching anything
              if (cap_num == CW'(0)) begin
                state      <= DONE;
                layer_done <= 1'b1;
              end else begin
                state        <= LAUNCH;
                pe_col_valid <= cap_active;
                fg_valid     <= 1'b1;
              end
            end
          end
          LAUNCH: begin
            launched         <= launched_nx;
            fg_launched      <= fg_launched_nx;
            col_done         <= col_done_nx;
            fg_done          <= fg_done_nx;
            layer_finish_col <= col_done_nx;
            if (all_launched) begin
              state        <= RUN;
              pe_col_valid <= '0;
              fg_valid     <= 1'b0;
            end else begin
              pe_col_valid <= active & ~launched_nx;
              fg_valid     <= ~fg_launched_nx;
            end
          end
          RUN: begin
            col_done         <= col_done_nx;
            fg_done          <= fg_done_nx;
            layer_finish_col <= col_done_nx;
            if (all_done) begin
              if (last_pass) begin
                state      <= DONE;
                layer_done <= 1'b1;
              end else begin
                // Next output-channel pass: relaunch everything from scratch
                state            <= LAUNCH;
                pass_idx         <= pass_idx + 8'd1;
                launched         <= '0;
                col_done         <= '0;
                fg_launched      <= 1'b0;
                fg_done          <= 1'b0;
                layer_finish_col <= '0;
                pe_col_valid     <= active;
                fg_valid         <= 1'b1;
              end
            end
          end
          DONE: begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            pass_idx  <= 8'd0;
            gate_col  <= '1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_layer_scheduler.sv
module tb_pe_layer_scheduler;

  localparam int unsigned N_COL = 4;
  localparam int unsigned CW    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CW-1:0]    cfg_col_num;
  logic [7:0]       cfg_co_pass;
  logic             abort;
  logic [N_COL-1:0] pe_col_valid;
  logic [N_COL-1:0] pe_col_ready;
  logic [N_COL-1:0] pe_col_finish;
  logic [N_COL-1:0] layer_finish_col;
  logic [N_COL-1:0] gate_col;
  logic             fg_valid;
  logic             fg_ready;
  logic             fg_finish;
  logic             busy;
  logic [7:0]       pass_idx;
  logic             layer_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int gate_viol = 0;

  pe_layer_scheduler #(.N_COL(N_COL), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_col_num(cfg_col_num), .cfg_co_pass(cfg_co_pass),
    .abort(abort),
    .pe_col_valid(pe_col_valid), .pe_col_ready(pe_col_ready),
    .pe_col_finish(pe_col_finish),
    .layer_finish_col(layer_finish_col), .gate_col(gate_col),
    .fg_valid(fg_valid), .fg_ready(fg_ready), .fg_finish(fg_finish),
    .busy(busy), .pass_idx(pass_idx), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  // Count layer_done pulses and any start request to a gated column
  always @(negedge clk) begin
    if (layer_done) done_cnt++;
    if ((pe_col_valid & gate_col) != '0) gate_viol++;
  end

  typedef struct {
    logic [CW-1:0]    col_num;
    logic [7:0]       co_pass;
    logic [N_COL-1:0] gate;
    logic [N_COL-1:0] active;
    int               passes;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one layer with all readies high and immediate finishes on the active columns
  task automatic run_layer(input vec_t v);
    int d0;
    d0 = done_cnt;
    pe_col_ready = '1;
    fg_ready     = 1'b1;
    cfg_col_num  = v.col_num;
    cfg_co_pass  = v.co_pass;
    cfg_valid    = 1'b1;
    chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    step();
    cfg_valid = 1'b0;
    chk("gate_col", 32'(gate_col), 32'(v.gate));
    chk("busy", 32'(busy), 32'd1);
    if (v.active == '0) begin
      chk("empty_done", 32'(layer_done), 32'd1);
      chk("empty_valid", 32'(pe_col_valid), 32'd0);
      chk("empty_fg_valid", 32'(fg_valid), 32'd0);
    end else begin
      for (int p = 0; p < v.passes; p++) begin
        chk("pass_idx", 32'(pass_idx), 32'(p));
        chk("launch_valid", 32'(pe_col_valid), 32'(v.active));
        chk("launch_fg_valid", 32'(fg_valid), 32'd1);
        chk("lfc_launch", 32'(layer_finish_col), 32'd0);
        step();
        chk("run_valid", 32'(pe_col_valid), 32'd0);
        pe_col_finish = v.active;
        fg_finish     = 1'b1;
        step();
        pe_col_finish = '0;
        fg_finish     = 1'b0;
        chk("lfc_run", 32'(layer_finish_col), 32'(v.active));
        chk("done_early", 32'(layer_done), 32'd0);
        step();
        if (p == v.passes - 1) chk("layer_done", 32'(layer_done), 32'd1);
      end
    end
    step();
    chk("done_drop", 32'(layer_done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gate", 32'(gate_col), 32'hf);
    chk("idle_ready", 32'(cfg_ready), 32'd1);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    vecs[0] = '{col_num: 3'd4, co_pass: 8'd1, gate: 4'b0000, active: 4'b1111, passes: 1};
    vecs[1] = '{col_num: 3'd2, co_pass: 8'd1, gate: 4'b1100, active: 4'b0011, passes: 1};
    vecs[2] = '{col_num: 3'd3, co_pass: 8'd3, gate: 4'b1000, active: 4'b0111, passes: 3};
    vecs[3] = '{col_num: 3'd0, co_pass: 8'd1, gate: 4'b1111, active: 4'b0000, passes: 1};
    vecs[4] = '{col_num: 3'd7, co_pass: 8'd1, gate: 4'b0000, active: 4'b1111, passes: 1};
    vecs[5] = '{col_num: 3'd1, co_pass: 8'd0, gate: 4'b1110, active: 4'b0001, passes: 1};
    vecs[6] = '{col_num: 3'd4, co_pass: 8'd2, gate: 4'b0000, active: 4'b1111, passes: 2};

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_col_num = '0; cfg_co_pass = '0; abort = 1'b0;
    pe_col_ready = '0; pe_col_finish = '0; fg_ready = 1'b0; fg_finish = 1'b0;
    #23;
    chk("rst_valid", 32'(pe_col_valid), 32'd0);
    chk("rst_fg_valid", 32'(fg_valid), 32'd0);
    chk("rst_lfc", 32'(layer_finish_col), 32'd0);
    chk("rst_gate", 32'(gate_col), 32'hf);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pass", 32'(pass_idx), 32'd0);
    chk("rst_done", 32'(layer_done), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", 32'(cfg_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_layer(vecs[i]);

    // Backpressure on column 1, early finish on column 0 during LAUNCH, late fg_finish
    begin
      int d0;
      d0 = done_cnt;
      pe_col_ready = 4'b1101; fg_ready = 1'b1;
      cfg_col_num = 3'd4; cfg_co_pass = 8'd1; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      chk("bp_valid_first", 32'(pe_col_valid), 32'hf);
      for (int k = 1; k < 10; k++) begin
        if (k == 2) pe_col_finish = 4'b0001;
        step();
        pe_col_finish = '0;
        chk("bp_valid_held", 32'(pe_col_valid), 32'b0010);
        chk("bp_fg_dropped", 32'(fg_valid), 32'd0);
        if (k == 3) chk("bp_lfc_launch", 32'(layer_finish_col), 32'b0001);
      end
      pe_col_ready = 4'b1111;
      step();
      chk("bp_run_valid", 32'(pe_col_valid), 32'd0);
      pe_col_finish = 4'b1110;
      step();
      pe_col_finish = '0;
      chk("bp_lfc_all", 32'(layer_finish_col), 32'hf);
      for (int k = 0; k < 3; k++) begin
        step();
        chk("bp_wait_fg", 32'(layer_done), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
      end
      fg_finish = 1'b1;
      step();
      fg_finish = 1'b0;
      chk("bp_fg_done_lag", 32'(layer_done), 32'd0);
      step();
      chk("bp_layer_done", 32'(layer_done), 32'd1);
      step();
      chk("bp_done_pulses", 32'(done_cnt - d0), 32'd1);
    end

    // Abort in RUN after two of four finishes
    begin
      int d0;
      d0 = done_cnt;
      pe_col_ready = '1; fg_ready = 1'b1;
      cfg_col_num = 3'd4; cfg_co_pass = 8'd2; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      step();
      pe_col_finish = 4'b0011;
      step();
      pe_col_finish = '0;
      chk("ab_lfc", 32'(layer_finish_col), 32'b0011);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_valid", 32'(pe_col_valid), 32'd0);
      chk("ab_fg_valid", 32'(fg_valid), 32'd0);
      chk("ab_gate", 32'(gate_col), 32'hf);
      chk("ab_lfc_clr", 32'(layer_finish_col), 32'd0);
      chk("ab_ready", 32'(cfg_ready), 32'd1);
      pe_col_finish = 4'b1100; fg_finish = 1'b1;
      step();
      pe_col_finish = '0; fg_finish = 1'b0;
      step();
      chk("ab_no_done", 32'(done_cnt - d0), 32'd0);
      run_layer(vecs[0]);
    end

    // Abort together with cfg_valid in IDLE: no capture
    abort = 1'b1; cfg_col_num = 3'd2; cfg_co_pass = 8'd1; cfg_valid = 1'b1;
    step();
    abort = 1'b0; cfg_valid = 1'b0;
    chk("abidle_busy", 32'(busy), 32'd0);
    chk("abidle_valid", 32'(pe_col_valid), 32'd0);
    chk("abidle_gate", 32'(gate_col), 32'hf);

    // Async reset while launching drops valids without a clock edge
    pe_col_ready = '0; fg_ready = 1'b0;
    cfg_col_num = 3'd3; cfg_co_pass = 8'd1; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("ar_valid_pre", 32'(pe_col_valid), 32'b0111);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(pe_col_valid), 32'd0);
    chk("ar_fg_valid", 32'(fg_valid), 32'd0);
    chk("ar_gate", 32'(gate_col), 32'hf);
    chk("ar_busy", 32'(busy), 32'd0);
    #10 rst_n = 1'b1;
    step();

    chk("gate_violations", 32'(gate_viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
